// File: rtl/tcdm_xbar_pipe.sv
// -----------------------------------------------------------------------------
// tcdm_xbar_pipe
//
// Full NumIn x NumOut TCDM crossbar between cluster initiators and SRAM banks.
// Each bank owns a round-robin arbiter. A request is granted when it wins its
// bank and the bank is ready. Responses return through a fixed-latency shift
// register per initiator.
//
// Address map: the bank index sits InterleaveShift word bits above the byte
// offset. The bank word address is formed from the remaining upper bits with
// the InterleaveShift low word bits appended below them.
//
// Ports
//   clk_i, rst_ni      clock (rising edge), synchronous active-low reset
//   req_i/add_i/wen_i/wdata_i/be_i   initiator request fields
//   gnt_o              initiator grant (combinational)
//   vld_o/rdata_o      initiator response, MemLatency cycles after handshake
//   cs_o/add_o/wen_o/wdata_o/be_o    bank request fields (winner's request)
//   gnt_i              bank ready
//   rdata_i            bank read data, sampled in the response cycle
//   clr_cnt_i          synchronous clear of the conflict counters
//   conflict_cnt_o     per-initiator saturating conflict counters
//
// Configuration macro: TCDM_XBAR_PERF_EN builds the conflict counters. When it
// is undefined, conflict_cnt_o is tied to 0 and clr_cnt_i is ignored.
// -----------------------------------------------------------------------------
module tcdm_xbar_pipe #(
    parameter int unsigned NumIn           = 16,
    parameter int unsigned NumOut          = 32,
    parameter int unsigned AddrWidth       = 32,
    parameter int unsigned DataWidth       = 32,
    parameter int unsigned BeWidth         = DataWidth / 8,
    parameter int unsigned AddrMemWidth    = 12,
    parameter int unsigned InterleaveShift = 0,
    parameter int unsigned MemLatency      = 1,
    parameter bit          WriteRespOn     = 1'b1
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic [NumIn-1:0]                       req_i,
    input  logic [NumIn-1:0][AddrWidth-1:0]        add_i,
    input  logic [NumIn-1:0]                       wen_i,
    input  logic [NumIn-1:0][DataWidth-1:0]        wdata_i,
    input  logic [NumIn-1:0][BeWidth-1:0]          be_i,
    output logic [NumIn-1:0]                       gnt_o,
    output logic [NumIn-1:0]                       vld_o,
    output logic [NumIn-1:0][DataWidth-1:0]        rdata_o,
    output logic [NumOut-1:0]                      cs_o,
    output logic [NumOut-1:0][AddrMemWidth-1:0]    add_o,
    output logic [NumOut-1:0]                      wen_o,
    output logic [NumOut-1:0][DataWidth-1:0]       wdata_o,
    output logic [NumOut-1:0][BeWidth-1:0]         be_o,
    input  logic [NumOut-1:0]                      gnt_i,
    input  logic [NumOut-1:0][DataWidth-1:0]       rdata_i,
    input  logic                                   clr_cnt_i,
    output logic [NumIn-1:0][31:0]                 conflict_cnt_o
);

    localparam int unsigned ByteOff = $clog2(DataWidth / 8);
    localparam int unsigned BankW   = $clog2(NumOut);
    localparam int unsigned InW     = $clog2(NumIn);
    localparam logic [AddrWidth-1:0] LoMask = AddrWidth'((64'd1 << InterleaveShift) - 64'd1);

    typedef logic [BankW-1:0] bank_t;
    typedef logic [InW-1:0]   idx_t;

    typedef struct packed {
        logic  valid;
        logic  is_write;
        bank_t bank;
    } resp_t;

    bank_t [NumIn-1:0]              w_bank;
    logic  [NumIn-1:0][AddrMemWidth-1:0] w_madd;
    logic  [NumOut-1:0]             w_win_vld;
    idx_t  [NumOut-1:0]             w_win;
    logic  [NumOut-1:0]             w_hs;
    idx_t  [NumOut-1:0]             r_ptr;
    resp_t                          r_pipe [NumIn][MemLatency];

    // Per-initiator address decode. Word address = add_i >> ByteOff; the bank
    // bits are removed and the InterleaveShift low bits close the gap.
    always_comb begin
        for (int j = 0; j < NumIn; j++) begin
            w_bank[j] = add_i[j][ByteOff+InterleaveShift +: BankW];
            w_madd[j] = AddrMemWidth'(
                (((add_i[j] >> ByteOff) >> (InterleaveShift + BankW)) << InterleaveShift) |
                ((add_i[j] >> ByteOff) & LoMask));
        end
    end

    // Round-robin winner per bank: first requester at index >= ptr, wrapping.
    // NumIn is a power of two, so idx_t arithmetic wraps modulo NumIn.
    always_comb begin
        idx_t idx;
        // NOTE: every signal written here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        idx       = '0;
        w_win_vld = '0;
        w_win     = '0;
        for (int b = 0; b < NumOut; b++) begin
            for (int k = 0; k < NumIn; k++) begin
                idx = r_ptr[b] + idx_t'(k);
                if (!w_win_vld[b] && req_i[idx] && (w_bank[idx] == bank_t'(b))) begin
                    w_win_vld[b] = 1'b1;
                    w_win[b]     = idx;
                end
            end
        end
    end

    // Bank-side fields and grants. Reset forces cs_o and gnt_o low; an idle
    // bank drives all-zero fields.
    always_comb begin
        cs_o    = '0;
        add_o   = '0;
        wen_o   = '0;
        wdata_o = '0;
        be_o    = '0;
        gnt_o   = '0;
        w_hs    = '0;
        for (int b = 0; b < NumOut; b++) begin
            if (rst_ni && w_win_vld[b]) begin
                cs_o[b]    = 1'b1;
                add_o[b]   = w_madd[w_win[b]];
                wen_o[b]   = wen_i[w_win[b]];
                wdata_o[b] = wdata_i[w_win[b]];
                be_o[b]    = be_i[w_win[b]];
                w_hs[b]    = gnt_i[b];
                if (gnt_i[b]) begin
                    gnt_o[w_win[b]] = 1'b1;
                end
            end
        end
    end

    // A stalled bank keeps its pointer, so the stalled winner stays first.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_ni) begin
            r_ptr <= '0;
        end else begin
            for (int b = 0; b < NumOut; b++) begin
                if (w_hs[b]) begin
                    r_ptr[b] <= w_win[b] + idx_t'(1);
                end
            end
        end
    end

    // Response shift register: stage 0 captures this cycle's handshake, stage
    // MemLatency-1 drives the response.
    always_ff @(posedge clk_i) begin
        // NOTE: this small register array is reset (unlike a data RAM) because
        // its valid bits must not replay in-flight responses after reset.
        if (!rst_ni) begin
            for (int j = 0; j < NumIn; j++) begin
                for (int s = 0; s < MemLatency; s++) begin
                    r_pipe[j][s] <= '0;
                end
            end
        end else begin
            for (int j = 0; j < NumIn; j++) begin
                r_pipe[j][0] <= '{valid: gnt_o[j], is_write: wen_i[j], bank: w_bank[j]};
                for (int s = 1; s < MemLatency; s++) begin
                    r_pipe[j][s] <= r_pipe[j][s-1];
                end
            end
        end
    end

    always_comb begin
        vld_o   = '0;
        rdata_o = '0;
        for (int j = 0; j < NumIn; j++) begin
            vld_o[j] = rst_ni & r_pipe[j][MemLatency-1].valid &
                       (~r_pipe[j][MemLatency-1].is_write | WriteRespOn);
            if (vld_o[j] && !r_pipe[j][MemLatency-1].is_write) begin
                rdata_o[j] = rdata_i[r_pipe[j][MemLatency-1].bank];
            end
        end
    end

`ifdef TCDM_XBAR_PERF_EN
    logic [NumIn-1:0][31:0] r_cnt;

    // Clear wins over a same-cycle increment; counts saturate at all-ones.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || clr_cnt_i) begin
            r_cnt <= '0;
        end else begin
            for (int j = 0; j < NumIn; j++) begin
                if (req_i[j] && !gnt_o[j] && (r_cnt[j] != 32'hFFFF_FFFF)) begin
                    r_cnt[j] <= r_cnt[j] + 32'd1;
                end
            end
        end
    end

    assign conflict_cnt_o = r_cnt;
`else
    logic w_unused_clr;
    assign w_unused_clr   = clr_cnt_i;
    assign conflict_cnt_o = '0;
`endif

endmodule
